// File: rtl/sap1_pkg.sv
// -----------------------------------------------------------------------------
// sap1_pkg
//   Shared constants for the SAP-1 controller/sequencer:
//     - opcode encodings (LDA/ADD/SUB/OUT/HLT)
//     - one-hot T-state constants T1..T6 (bit0 = T1)
//     - bit positions of the 12-bit control word
//       {Cp Ep nLm nCE nLi nEi nLa Ea Su Eu nLb nLo}
//     - cw_decode(): Moore decode of T-state and opcode into a control word
// -----------------------------------------------------------------------------
package sap1_pkg;

    localparam int RING_LEN = 6;
    localparam int OPCODE_W = 4;
    localparam int CW_W     = 12;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    localparam logic [RING_LEN-1:0] T1 = 6'b000001;
    localparam logic [RING_LEN-1:0] T2 = 6'b000010;
    localparam logic [RING_LEN-1:0] T3 = 6'b000100;
    localparam logic [RING_LEN-1:0] T4 = 6'b001000;
    localparam logic [RING_LEN-1:0] T5 = 6'b010000;
    localparam logic [RING_LEN-1:0] T6 = 6'b100000;

    // Control-word field positions, MSB first.
    localparam int CW_CP  = 11;
    localparam int CW_EP  = 10;
    localparam int CW_NLM = 9;
    localparam int CW_NCE = 8;
    localparam int CW_NLI = 7;
    localparam int CW_NEI = 6;
    localparam int CW_NLA = 5;
    localparam int CW_EA  = 4;
    localparam int CW_SU  = 3;
    localparam int CW_EU  = 2;
    localparam int CW_NLB = 1;
    localparam int CW_NLO = 0;

    // Every signal deasserted: active-high bits 0, active-low bits 1.
    localparam logic [CW_W-1:0] CW_IDLE = 12'b0011_1110_0011;

    // Starts from the idle word and only flips the fields that the current
    // state/opcode asserts; anything not mentioned stays inactive.
    function automatic logic [CW_W-1:0] cw_decode(
        input logic [RING_LEN-1:0] t,
        input logic [OPCODE_W-1:0] op
    );
        logic [CW_W-1:0] cw;
        cw = CW_IDLE;
        case (t)
            T1: begin
                cw[CW_EP]  = 1'b1;
                cw[CW_NLM] = 1'b0;
            end
            T2: begin
                cw[CW_CP]  = 1'b1;
            end
            T3: begin
                cw[CW_NCE] = 1'b0;
                cw[CW_NLI] = 1'b0;
            end
            T4: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_NEI] = 1'b0;
                        cw[CW_NLM] = 1'b0;
                    end
                    OP_OUT: begin
                        cw[CW_EA]  = 1'b1;
                        cw[CW_NLO] = 1'b0;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (op)
                    OP_LDA: begin
                        cw[CW_NCE] = 1'b0;
                        cw[CW_NLA] = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_NCE] = 1'b0;
                        cw[CW_NLB] = 1'b0;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (op)
                    OP_ADD: begin
                        cw[CW_EU]  = 1'b1;
                        cw[CW_NLA] = 1'b0;
                    end
                    OP_SUB: begin
                        cw[CW_EU]  = 1'b1;
                        cw[CW_NLA] = 1'b0;
                        cw[CW_SU]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// -----------------------------------------------------------------------------
// sap1_ring_counter
//   One-hot ring counter for the SAP-1 T-states. Rotates left by one on each
//   rising edge where adv_i=1 and hold_i=0; the MSB wraps to bit0.
//   Ports:
//     clk_i     in  clock, rising edge
//     clr_i     in  synchronous active-high clear, forces bit0 (T1)
//     hold_i    in  freeze the current state
//     adv_i     in  advance enable for this edge
//     tstate_o  out one-hot state, bit0 = T1
// -----------------------------------------------------------------------------
module sap1_ring_counter
    import sap1_pkg::*;
#(
    parameter int N = RING_LEN
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         hold_i,
    input  logic         adv_i,
    output logic [N-1:0] tstate_o
);

    logic [N-1:0] tstate_q;
    logic [N-1:0] tstate_d;

    always_comb begin
        tstate_d = tstate_q;
        if (adv_i && !hold_i)
            tstate_d = {tstate_q[N-2:0], tstate_q[N-1]};
    end

    always_ff @(posedge clk_i) begin
        if (clr_i)
            tstate_q <= {{(N-1){1'b0}}, 1'b1};
        else
            tstate_q <= tstate_d;
    end

    assign tstate_o = tstate_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap1_controller_sequencer
//   SAP-1 control unit: 6-state one-hot ring counter plus instruction decoder
//   and HLT flag. Produces the 12-bit control word as individual pins.
//   Optional feature macro: SAP_SINGLE_STEP_EN (adds the step input; the ring
//   advances only on edges where step has risen since the previous edge).
//   Ports:
//     CLK          in  system clock, rising edge
//     CLR          in  synchronous active-high reset; also forces outputs idle
//     opcode[3:0]  in  IR upper nibble, stable T4..T6
//     step         in  single-step request (SAP_SINGLE_STEP_EN only)
//     Cp Ep Ea Su Eu             out active-high controls
//     nLm nCE nLi nEi nLa nLb nLo out active-low controls
//     tstate[5:0]  out one-hot T-state, bit0 = T1
//     halted       out HLT executed, sequencer frozen until CLR
// -----------------------------------------------------------------------------
module sap1_controller_sequencer
    import sap1_pkg::*;
#(
    parameter int RING_LEN_P = RING_LEN,
    parameter int OPCODE_W_P = OPCODE_W
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [OPCODE_W_P-1:0] opcode,
`ifdef SAP_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic                  Cp,
    output logic                  Ep,
    output logic                  nLm,
    output logic                  nCE,
    output logic                  nLi,
    output logic                  nEi,
    output logic                  nLa,
    output logic                  Ea,
    output logic                  Su,
    output logic                  Eu,
    output logic                  nLb,
    output logic                  nLo,
    output logic [RING_LEN_P-1:0] tstate,
    output logic                  halted
);

    logic            adv;
    logic            hold;
    logic            hlt_in_t4;
    logic            halted_q;
    logic            halted_d;
    logic [CW_W-1:0] cw;

`ifdef SAP_SINGLE_STEP_EN
    // Edge detector: one advance per rising edge of step, however long it is held.
    logic step_q;

    always_ff @(posedge CLK) begin
        if (CLR)
            step_q <= 1'b0;
        else
            step_q <= step;
    end

    assign adv = step & ~step_q;
`else
    assign adv = 1'b1;
`endif

    // The HLT state itself must not advance: the ring stays on T4 through the
    // edge that sets halted, and from then on halted_q keeps it there.
    assign hlt_in_t4 = (tstate == T4) && (opcode == OP_HLT);
    assign hold      = halted_q | hlt_in_t4;

    sap1_ring_counter #(
        .N (RING_LEN_P)
    ) u_ring (
        .clk_i    (CLK),
        .clr_i    (CLR),
        .hold_i   (hold),
        .adv_i    (adv),
        .tstate_o (tstate)
    );

    always_comb begin
        halted_d = halted_q;
        if (adv && hlt_in_t4)
            halted_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (CLR)
            halted_q <= 1'b0;
        else
            halted_q <= halted_d;
    end

    assign halted = halted_q;

    // CLR and halt win over decode combinationally, so nothing downstream
    // latches a partial instruction on the clearing edge. Without an advance
    // grant (single-step idle cycles) the word is idle so loads happen once.
    always_comb begin
        cw = CW_IDLE;
        if (!CLR && !halted_q && adv)
            cw = cw_decode(tstate, opcode);
    end

    assign Cp  = cw[CW_CP];
    assign Ep  = cw[CW_EP];
    assign nLm = cw[CW_NLM];
    assign nCE = cw[CW_NCE];
    assign nLi = cw[CW_NLI];
    assign nEi = cw[CW_NEI];
    assign nLa = cw[CW_NLA];
    assign Ea  = cw[CW_EA];
    assign Su  = cw[CW_SU];
    assign Eu  = cw[CW_EU];
    assign nLb = cw[CW_NLB];
    assign nLo = cw[CW_NLO];

endmodule
